// File: rtl/ob_pkg.sv
// Order-book shared types plus the response-serialiser additions: response classes,
// per-class payload byte counts and the CRC-8 (poly 0x07) step used by ob_rsp_ser.
package ob_pkg;

    typedef logic [3:0]  status_t;
    typedef logic [15:0] uid_t;
    typedef logic [23:0] price_t;
    typedef logic [15:0] quantity_t;

    localparam status_t ST_ACK    = 4'd1;
    localparam status_t ST_REJECT = 4'd2;
    localparam status_t ST_QRY    = 4'd3;
    localparam status_t ST_POP    = 4'd4;
    localparam status_t ST_TRADE  = 4'd5;
    localparam status_t ST_CANCEL = 4'd6;

    typedef struct packed {
        status_t   status;
        uid_t      uid;
        price_t    bid;
        price_t    ask;
        price_t    price;
        quantity_t quantity;
        uid_t      bid_uid;
        uid_t      ask_uid;
    } rsp_t;

    typedef enum logic [1:0] {CLS_NONE, CLS_QRY, CLS_POP, CLS_TRADE} rsp_class_t;

    typedef enum logic [1:0] {StIdle, StLoad, StSend} ser_state_e;

    localparam int unsigned RSP_SER_HDR_B   = 5;
    localparam int unsigned RSP_SER_QRY_B   = 8;
    localparam int unsigned RSP_SER_POP_B   = 12;
    localparam int unsigned RSP_SER_TRADE_B = 12;
    localparam int unsigned RSP_SER_MAX_B   = 17;

    // Unlisted status codes carry no payload.
    function automatic rsp_class_t rsp_class(status_t s);
        case (s)
            ST_QRY:   return CLS_QRY;
            ST_POP:   return CLS_POP;
            ST_TRADE: return CLS_TRADE;
            default:  return CLS_NONE;
        endcase
    endfunction

    function automatic logic [7:0] crc8_byte(logic [7:0] crc, logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ob_rsp_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Storage is not reset, only pointers and count are.
module ob_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push && (count_q < (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ob_rsp_ser.sv
// Buffers order-book responses and serialises each into a big-endian byte frame on a
// valid/ready stream. Define OB_RSP_SER_CRC_EN to append a CRC-8 byte to every frame.
module ob_rsp_ser
    import ob_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rsp_vld,
    input  logic [$bits(rsp_t)-1:0] rsp,
    output logic                   rsp_accept,
    output logic                   out_vld,
    output logic [7:0]             out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [15:0]            frm_cnt_r
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SH_W  = 8 * RSP_SER_MAX_B;
`ifdef OB_RSP_SER_CRC_EN
    localparam int unsigned CRC_B = 1;
`else
    localparam int unsigned CRC_B = 0;
`endif

    if ($bits(uid_t) > 32 || $bits(price_t) > 32 || $bits(quantity_t) > 32) begin : g_width_chk
        $error("ob_rsp_ser: uid_t, price_t and quantity_t must be at most 32 bits");
    end

    ser_state_e       state_q, state_d;
    rsp_t             head;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   cnt_nxt;
    logic             push, pop, hs, last;
    logic             accept_q;
    logic [SH_W-1:0]  shreg_q, frame;
    logic [4:0]       bcnt_q, frame_len;
    logic [15:0]      frm_cnt_q;
    logic [7:0]       cur_byte;
    logic [39:0]      hdr;

    ob_rsp_fifo #(
        .WIDTH($bits(rsp_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(rsp),
        .pop  (pop),
        .rdata(head),
        .count(fifo_cnt)
    );

    assign push    = rsp_vld & accept_q;
    assign pop     = (state_q == StLoad);
    assign hs      = (state_q == StSend) & out_ready;
    assign last    = (bcnt_q == '0);
    assign cnt_nxt = {1'b0, fifo_cnt} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

    always_comb begin
        hdr       = {8'(head.status), 32'(head.uid)};
        frame     = {hdr, 96'b0};
        frame_len = 5'(RSP_SER_HDR_B + CRC_B);
        case (rsp_class(head.status))
            CLS_QRY: begin
                frame     = {hdr, 32'(head.bid), 32'(head.ask), 32'b0};
                frame_len = 5'(RSP_SER_HDR_B + RSP_SER_QRY_B + CRC_B);
            end
            CLS_POP: begin
                frame     = {hdr, 32'(head.price), 32'(head.quantity), 32'(head.uid)};
                frame_len = 5'(RSP_SER_HDR_B + RSP_SER_POP_B + CRC_B);
            end
            CLS_TRADE: begin
                frame     = {hdr, 32'(head.bid_uid), 32'(head.ask_uid), 32'(head.quantity)};
                frame_len = 5'(RSP_SER_HDR_B + RSP_SER_TRADE_B + CRC_B);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (fifo_cnt != '0) state_d = StLoad;
            StLoad: state_d = StSend;
            StSend: if (hs && last) state_d = (fifo_cnt != '0) ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef OB_RSP_SER_CRC_EN
    logic [7:0] crc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else if (state_q == StLoad) begin
            crc_q <= '0;
        end else if (hs && !last) begin
            crc_q <= crc8_byte(crc_q, shreg_q[SH_W-1 -: 8]);
        end
    end

    assign cur_byte = last ? crc_q : shreg_q[SH_W-1 -: 8];
`else
    assign cur_byte = shreg_q[SH_W-1 -: 8];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accept_q  <= 1'b0;
            shreg_q   <= '0;
            bcnt_q    <= '0;
            frm_cnt_q <= '0;
        end else begin
            accept_q <= (cnt_nxt < (CNT_W+1)'(FIFO_DEPTH));
            if (state_q == StLoad) begin
                shreg_q <= frame;
                bcnt_q  <= frame_len - 5'd1;
            end else if (hs) begin
                shreg_q <= shreg_q << 8;
                bcnt_q  <= bcnt_q - 5'd1;
                if (last) frm_cnt_q <= frm_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        out_vld  = (state_q == StSend);
        out_last = out_vld & last;
        out_data = out_vld ? cur_byte : 8'h00;
    end

    assign rsp_accept = accept_q;
    assign busy       = (fifo_cnt != '0) | (state_q != StIdle);
    assign frm_cnt_r  = frm_cnt_q;

endmodule

// File: tb/tb_ob_rsp_ser.sv
// Self-checking bench for ob_rsp_ser: expected frames come from a byte-level model of
// the frame format (with CRC-8 when OB_RSP_SER_CRC_EN is defined).
module tb_ob_rsp_ser;
    import ob_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rsp_vld = 1'b0;
    rsp_t        rsp = '0;
    logic        rsp_accept;
    logic        out_vld;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [15:0] frm_cnt_r;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  obs_data[$];
    logic        obs_last[$];
    logic [7:0]  exp_data[$];
    logic        exp_last[$];
    logic [15:0] exp_frames = '0;

    ob_rsp_ser #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rsp_vld   (rsp_vld),
        .rsp       (rsp),
        .rsp_accept(rsp_accept),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .frm_cnt_r (frm_cnt_r)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a negedge sample predicts the handshake.
    always @(negedge clk) begin
        if (rst && out_vld && out_ready) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
        end
    end

    task automatic model_frame(input rsp_t r);
        logic [31:0] w[$];
        logic [7:0]  b[$];
        logic [7:0]  crc;
        w.push_back(32'(r.uid));
        case (r.status)
            ST_QRY:   begin w.push_back(32'(r.bid)); w.push_back(32'(r.ask)); end
            ST_POP:   begin w.push_back(32'(r.price)); w.push_back(32'(r.quantity));
                            w.push_back(32'(r.uid)); end
            ST_TRADE: begin w.push_back(32'(r.bid_uid)); w.push_back(32'(r.ask_uid));
                            w.push_back(32'(r.quantity)); end
            default: ;
        endcase
        b.push_back(8'(r.status));
        foreach (w[i]) for (int k = 3; k >= 0; k--) b.push_back(8'(w[i] >> (8 * k)));
`ifdef OB_RSP_SER_CRC_EN
        crc = 8'h00;
        foreach (b[i]) begin
            crc = crc ^ b[i];
            for (int k = 0; k < 8; k++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        b.push_back(crc);
`else
        crc = 8'h00;
`endif
        foreach (b[i]) begin
            exp_data.push_back(b[i]);
            exp_last.push_back(i == b.size() - 1);
        end
        exp_frames = exp_frames + 16'd1;
    endtask

    function automatic rsp_t rand_rsp();
        rsp_t r;
        r.status   = status_t'($urandom_range(0, 15));
        r.uid      = uid_t'($urandom);
        r.bid      = price_t'($urandom);
        r.ask      = price_t'($urandom);
        r.price    = price_t'($urandom);
        r.quantity = quantity_t'($urandom);
        r.bid_uid  = uid_t'($urandom);
        r.ask_uid  = uid_t'($urandom);
        return r;
    endfunction

    // Offer r until accepted or max_wait cycles pass; on timeout rsp_vld stays high.
    task automatic send(input rsp_t r, input int max_wait, output bit ok);
        ok = 1'b0;
        rsp = r;
        rsp_vld = 1'b1;
        for (int c = 0; c < max_wait; c++) begin
            @(negedge clk);
            if (rsp_accept) begin
                @(posedge clk);
                #1;
                rsp_vld = 1'b0;
                model_frame(r);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        obs_data.delete(); obs_last.delete();
        exp_data.delete(); exp_last.delete();
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({rsp_accept, out_vld, out_data, out_last, busy, frm_cnt_r} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_values: got acc=%b vld=%b data=%h last=%b busy=%b cnt=%0d, want all 0",
                     rsp_accept, out_vld, out_data, out_last, busy, frm_cnt_r);
        end
        @(posedge clk); #1; rst = 1'b1;
        n_cmp++;
        if (rsp_accept !== 1'b0) begin
            n_err++; $display("FAIL reset_accept_low: got %b want 0", rsp_accept);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_accept !== 1'b1) begin
            n_err++; $display("FAIL reset_accept_rise: got %b want 1", rsp_accept);
        end
    endtask

    task automatic test_none();
        rsp_t r;
        bit   ok;
        clear_q();
        r = rand_rsp();
        r.status = ST_ACK;
        r.uid = 16'h00A5;
        rsp = r; rsp_vld = 1'b1;
        @(posedge clk); #1; rsp_vld = 1'b0;
        model_frame(r);
        @(negedge clk);
        n_cmp++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL none_lat_n0: got %b want 0", out_vld); end
        @(negedge clk);
        n_cmp++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL none_lat_n1: got %b want 0", out_vld); end
        @(negedge clk);
        n_cmp++;
        if (out_vld !== 1'b1 || out_data !== 8'(ST_ACK)) begin
            n_err++;
            $display("FAIL none_lat_n2: got vld=%b data=%h want vld=1 data=%h",
                     out_vld, out_data, 8'(ST_ACK));
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL none_drain: busy still %b, want 0", busy); end
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL none_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL none_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (frm_cnt_r !== exp_frames) begin
            n_err++; $display("FAIL none_frm_cnt: got %0d want %0d", frm_cnt_r, exp_frames);
        end
    endtask

    task automatic test_qry();
        rsp_t r;
        bit   ok;
        clear_q();
        r = rand_rsp();
        r.status = ST_QRY;
        r.uid = 16'h0001;
        r.bid = 24'h01_2345;
        r.ask = 24'h01_2350;
        send(r, 20, ok);
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL qry_drain: busy still %b, want 0", busy); end
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL qry_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL qry_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_trade_stall();
        rsp_t       r;
        bit         ok, prev_stall;
        logic [7:0] pd;
        logic       pl;
        clear_q();
        r = rand_rsp();
        r.status = ST_TRADE;
        send(r, 20, ok);
        prev_stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (out_vld !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    n_err++;
                    $display("FAIL trade_stall_hold: got vld=%b data=%h last=%b want 1/%h/%b",
                             out_vld, out_data, out_last, pd, pl);
                end
            end
            prev_stall = out_vld && !out_ready;
            pd = out_data;
            pl = out_last;
            if (!busy) break;
            @(posedge clk); #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL trade_drain: busy still %b, want 0", busy); end
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL trade_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL trade_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_t r[6];
        bit   ok;
        int   accepted;
        clear_q();
        foreach (r[i]) r[i] = rand_rsp();
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            send(r[i], 10, ok);
            if (!ok) break;
            accepted++;
        end
        // One response leaves the FIFO into the frame register, so DEPTH+1 fit in total.
        n_cmp++;
        if (accepted != DEPTH + 1 || rsp_accept !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d accepted, acc=%b want %0d, acc=0",
                     accepted, rsp_accept, DEPTH + 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = accepted; i < 6; i++) begin
            send(r[i], 200, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL bp_send%0d: got no accept, want accept", i); end
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_drain: busy still %b, want 0", busy); end
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL bp_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL bp_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (frm_cnt_r !== exp_frames) begin
            n_err++; $display("FAIL bp_frm_cnt: got %0d want %0d", frm_cnt_r, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        rsp_t r;
        bit   ok;
        clear_q();
        r = rand_rsp();
        r.status = ST_POP;
        out_ready = 1'b1;
        send(r, 20, ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (obs_data.size() >= 7) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_reach: got %0d bytes want 7", obs_data.size()); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || frm_cnt_r !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_abort: got vld=%b busy=%b data=%h cnt=%0d want 0/0/00/0",
                     out_vld, busy, out_data, frm_cnt_r);
        end
        clear_q();
        exp_frames = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_accept !== 1'b1) begin
            n_err++; $display("FAIL rstmid_accept: got %b want 1", rsp_accept);
        end
        r = rand_rsp();
        r.status = ST_REJECT;
        send(r, 20, ok);
        drain(ok);
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL rstmid_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL rstmid_byte%0d: got %h/%b want %h/%b", i, obs_data[i],
                         obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (frm_cnt_r !== exp_frames) begin
            n_err++; $display("FAIL rstmid_frm_cnt: got %0d want %0d", frm_cnt_r, exp_frames);
        end
    endtask

    task automatic test_random();
        bit ok, done, all_ok;
        clear_q();
        done = 1'b0;
        all_ok = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(rand_rsp(), 500, ok);
                    if (!ok) all_ok = 1'b0;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain(ok);
        n_cmp++;
        if (!(ok && all_ok)) begin
            n_err++; $display("FAIL rand_progress: drained=%b sends_ok=%b want 1/1", ok, all_ok);
        end
        n_cmp++;
        if (obs_data.size() != exp_data.size()) begin
            n_err++;
            $display("FAIL rand_len: got %0d bytes want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL rand_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (frm_cnt_r !== exp_frames) begin
            n_err++; $display("FAIL rand_frm_cnt: got %0d want %0d", frm_cnt_r, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_qry();
        test_trade_stall();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
